rf_wr_arbiter: RTL and testbench
================================

// Module: rf_wr_arbiter
// PURPOSE
//   Owns the single write port of the 32x32 register file (a3/wd/rfwr). It shares
//   that port between NREQ requesters, such as CPU writeback and a debug/load
//   unit, using round-robin arbitration and a valid/ready handshake.
//   After reset, or on request, it runs a clear sequence that zeroes r1..r31.
//   Sits between the requesters and the register file. Read ports are untouched.
// PARAMETERS
//   NREQ    2   number of write requesters (>=2)
//   ADDR_W  5   register address width (2**ADDR_W registers)
//   DATA_W  32  register data width
// PORTS
//   clk          in   1            clock; all state and the RF write on rising edge
//   rst_n        in   1            reset, asynchronous, active-low
//   req_valid    in   NREQ         per-requester write request
//   req_addr     in   NREQ*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
//   req_data     in   NREQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
//   req_ready    out  NREQ         one-hot grant; request accepted on edge when valid&ready
//   clear_start  in   1            pulse: zero r1..r31
//   busy         out  1            high while clearing
//   rf_a3        out  ADDR_W       to RF a3
//   rf_wd        out  DATA_W       to RF wd
//   rf_rfwr      out  1            to RF rfwr (active-high write enable)
// BEHAVIOUR
//   - Reset: rf_a3=0, rf_wd=0, rf_rfwr=0, busy=0, req_ready=0.
//     RR pointer=NREQ-1. State enters CLEAR on the first edge after rst_n rises.
//   - FSM states: CLEAR, ARB.
//     CLEAR -> ARB after the write to address 31.
//     ARB -> CLEAR when clear_start=1.
//   - CLEAR: clear counter starts at 1 and increments by 1 per cycle.
//     * Each edge registers rf_a3=cnt, rf_wd=0, rf_rfwr=1.
//     * Sequence is 31 writes, r1..r31. r0 is never written (hardwired zero).
//     * busy=1 throughout. req_ready=0. clear_start ignored.
//   - ARB arbitration:
//     * req_ready is combinational from req_valid.
//     * Exactly one bit is set: the first valid requester searching from
//       pointer+1 upward, modulo NREQ.
//     * All zero if no request is valid, or if clear_start=1 that cycle
//       (clear wins).
//   - Accept: on an edge with req_valid[i]&req_ready[i]:
//     * rf_a3 <= req_addr[i]; rf_wd <= req_data[i];
//       rf_rfwr <= (req_addr[i]!=0). pointer <= i.
//     * Latency: accepted at edge N. rf_rfwr is high during cycle N+1 and the
//       RF writes at edge N+1.
//     * Without an accept, rf_rfwr <= 0. rf_a3/rf_wd hold their last value.
//   - Address 0 writes are accepted (ready=1) and silently dropped (rf_rfwr=0).
//   - Requesters hold valid/addr/data stable until accepted. There is no
//     combinational path from req_ready to req_valid.
//   - Throughput: one write per cycle. With all requesters valid, grants rotate
//     0,1,..,NREQ-1,0.
//   - Reset mid-clear or mid-accept: outputs return to reset values immediately.
//     The clear restarts from r1 after release. In-flight writes are lost.
//   - Reads issued during CLEAR may return stale data. Consumers gate on busy.
// TESTING
//   1. Release rst_n -> busy=1 for 31 cycles; rf_rfwr=1 with rf_a3=1..31 and
//      rf_wd=0; then busy=0. All RF reads return 0.
//   2. After clear, req_valid=01, addr 5, data 0xDEADBEEF -> req_ready=01 the
//      same cycle. Next cycle rf_a3=5, rf_wd=0xDEADBEEF, rf_rfwr=1. Then
//      rd(5)=0xDEADBEEF.
//   3. req_valid=11 held for 6 cycles, each requester using a distinct address ->
//      grants 0,1,0,1,0,1. RF contains the last data of each requester.
//   4. req_valid=01 with addr 0, data 0x12345678 -> req_ready=01, rf_rfwr stays
//      0, rd(0)=0.
//   5. In ARB, pulse clear_start while req_valid=10 -> req_ready=00 that cycle.
//      Then 31 clear writes follow. Only then is requester 1 granted and its
//      write lands after the clear.
//   6. Assert rst_n low at clear write 10 -> rf_rfwr=0 immediately. After
//      release the clear restarts at rf_a3=1 and completes 31 writes.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: owns the single register-file write port.
// Shares the port between NREQ requesters with round-robin arbitration and a
// valid/ready handshake. After reset, or on a clear_start pulse, it zeroes
// r1..r(2**ADDR_W-1) before any requester is served. r0 is never written.
//
// state | meaning
// ------+---------------------------------------------------------------
// RST   | first cycle after reset release; nothing granted, busy low
// CLEAR | writing zero to r1..rLAST, one register per cycle, busy high
// ARB   | round-robin arbitration of requesters, one accept per cycle

module rf_wr_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     clear_start,
    output logic                     busy,
    output logic [ADDR_W-1:0]        rf_a3,
    output logic [DATA_W-1:0]        rf_wd,
    output logic                     rf_rfwr
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CLR_LAST  = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ARB   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [NREQ-1:0]    grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               accept;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear_start is only honoured while arbitrating
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:   state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_cnt == CLR_LAST) state_nxt = ST_ARB;
            ST_ARB:   if (clear_start) state_nxt = ST_CLEAR;
            default:  state_nxt = ST_RST;
        endcase
    end

    // Round-robin search: first valid requester starting just after the pointer
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PTR_W'(idx);
            end
        end
    end

    // Output logic: grants only in ARB, and a clear request pre-empts them
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        case (state)
            ST_CLEAR: busy = 1'b1;
            ST_ARB:   if (!clear_start) req_ready = grant;
            default:  ;
        endcase
    end

    assign accept   = |req_ready;
    assign sel_addr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign sel_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

    // Write-port datapath, clear counter and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_a3   <= '0;
            rf_wd   <= '0;
            rf_rfwr <= 1'b0;
            clr_cnt <= CLR_FIRST;
            rr_ptr  <= PTR_W'(NREQ - 1);
        end else begin
            case (state)
                ST_CLEAR: begin
                    rf_a3   <= clr_cnt;
                    rf_wd   <= '0;
                    rf_rfwr <= 1'b1;
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                end
                ST_ARB: begin
                    // Reload so the next clear always starts from r1
                    clr_cnt <= CLR_FIRST;
                    if (accept) begin
                        rf_a3   <= sel_addr;
                        rf_wd   <= sel_data;
                        // r0 is hardwired zero: accept the request but drop the write
                        rf_rfwr <= (sel_addr != '0);
                        rr_ptr  <= grant_idx;
                    end else begin
                        rf_rfwr <= 1'b0;
                    end
                end
                default: begin
                    rf_rfwr <= 1'b0;
                    clr_cnt <= CLR_FIRST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
module tb_rf_wr_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic                    clk;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*ADDR_W-1:0]  req_addr;
    logic [NREQ*DATA_W-1:0]  req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    clear_start;
    logic                    busy;
    logic [ADDR_W-1:0]       rf_a3;
    logic [DATA_W-1:0]       rf_wd;
    logic                    rf_rfwr;

    int compared   = 0;
    int mismatched = 0;

    // expected writes {addr, data}, in the order they must reach the RF port
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    // register file as built from the DUT's write port
    logic [DATA_W-1:0] rf_mem [0:31];

    rf_wr_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .busy        (busy),
        .rf_a3       (rf_a3),
        .rf_wd       (rf_wd),
        .rf_rfwr     (rf_rfwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_clear();
        for (int r = 1; r < 32; r++) push(ADDR_W'(r), '0);
    endtask

    // wait for busy, then count its length (bounded)
    task automatic clear_len(input string tag);
        int n;
        n = 0;
        while (!busy && n < 5) begin tick(); n++; end
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk({tag, "_busy_cycles"}, 32'(n), 32'd31);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard: every RF write must match the next expected one
    always @(negedge clk) begin
        if (rf_rfwr === 1'b1) begin
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_write observed a3=%0d wd=0x%08h expected none", rf_a3, rf_wd);
            end
            if (exp_q.size() != 0) begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(rf_a3), 32'(e[DATA_W +: ADDR_W]));
                chk("wr_data", rf_wd, e[DATA_W-1:0]);
            end
            rf_mem[rf_a3] = rf_wd;
        end
    end

    initial begin
        int n;
        logic [DATA_W-1:0] d0, d1;
        for (int r = 0; r < 32; r++) rf_mem[r] = 32'hFFFF_FFFF;
        rf_mem[0] = '0;
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; clear_start = 1'b0;
        #12;
        // reset values
        chk("rst_rfwr",  32'(rf_rfwr),   32'd0);
        chk("rst_a3",    32'(rf_a3),     32'd0);
        chk("rst_wd",    rf_wd,          32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // 1: clear after reset
        tick();
        push_clear();
        rst_n = 1'b1;
        clear_len("t1");
        drain("t1");
        for (int r = 1; r < 32; r++) chk("t1_rf_zero", rf_mem[r], 32'd0);

        // 2: single write from requester 0
        req_valid = 2'b01; req_addr[0 +: 5] = 5'd5; req_data[0 +: 32] = 32'hDEAD_BEEF;
        #1;
        chk("t2_ready", 32'(req_ready), 32'b01);
        push(5'd5, 32'hDEAD_BEEF);
        tick();
        req_valid = '0;
        chk("t2_a3",   32'(rf_a3),   32'd5);
        chk("t2_wd",   rf_wd,        32'hDEAD_BEEF);
        chk("t2_rfwr", 32'(rf_rfwr), 32'd1);
        tick();
        chk("t2_rd5", rf_mem[5], 32'hDEAD_BEEF);

        // requester 1 alone: pointer is 0, so it is searched first
        req_valid = 2'b10; req_addr[5 +: 5] = 5'd7; req_data[32 +: 32] = 32'h0000_0077;
        #1;
        chk("t3_pre_ready", 32'(req_ready), 32'b10);
        push(5'd7, 32'h0000_0077);
        tick();

        // 3: both valid for 6 cycles -> grants alternate 0,1,0,1,0,1
        d0 = 32'hA000_0000; d1 = 32'hB000_0000;
        req_addr[0 +: 5] = 5'd10; req_addr[5 +: 5] = 5'd11;
        for (int k = 0; k < 6; k++) begin
            req_valid = 2'b11; req_data[0 +: 32] = d0; req_data[32 +: 32] = d1;
            #1;
            chk("t3_grant", 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
            if (k % 2 == 0) push(5'd10, d0); else push(5'd11, d1);
            tick();
            if (k % 2 == 0) d0 = d0 + 1; else d1 = d1 + 1;
        end
        req_valid = '0;
        drain("t3");
        chk("t3_rd10", rf_mem[10], 32'hA000_0002);
        chk("t3_rd11", rf_mem[11], 32'hB000_0002);

        // 4: address 0 accepted but not written
        req_valid = 2'b01; req_addr[0 +: 5] = 5'd0; req_data[0 +: 32] = 32'h1234_5678;
        #1;
        chk("t4_ready", 32'(req_ready), 32'b01);
        tick();
        req_valid = '0;
        chk("t4_rfwr", 32'(rf_rfwr), 32'd0);
        chk("t4_a3",   32'(rf_a3),   32'd0);
        chk("t4_wd",   rf_wd,        32'h1234_5678);
        tick();
        chk("t4_rd0", rf_mem[0], 32'd0);

        // 5: clear_start pre-empts a pending request
        req_valid = 2'b10; req_addr[5 +: 5] = 5'd9; req_data[32 +: 32] = 32'hCAFE_F00D;
        clear_start = 1'b1;
        #1;
        chk("t5_ready_clr", 32'(req_ready), 32'b00);
        push_clear();
        push(5'd9, 32'hCAFE_F00D);
        tick();
        clear_start = 1'b0;
        chk("t5_busy", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 40) begin
            chk("t5_ready_busy", 32'(req_ready), 32'b00);
            tick();
            n++;
        end
        chk("t5_busy_cycles", 32'(n), 32'd31);
        chk("t5_ready_after", 32'(req_ready), 32'b10);
        tick();
        req_valid = '0;
        drain("t5");
        chk("t5_rd9", rf_mem[9], 32'hCAFE_F00D);

        // 6: reset in the middle of a clear
        clear_start = 1'b1;
        push_clear();
        tick();
        clear_start = 1'b0;
        n = 0;
        while (!(rf_rfwr === 1'b1 && rf_a3 === 5'd10) && n < 40) begin tick(); n++; end
        chk("t6_reach10", 32'(rf_a3), 32'd10);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rfwr", 32'(rf_rfwr), 32'd0);
        chk("t6_rst_a3",   32'(rf_a3),   32'd0);
        chk("t6_rst_busy", 32'(busy),    32'd0);
        exp_q.delete();
        push_clear();
        tick();
        tick();
        rst_n = 1'b1;
        clear_len("t6");
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
